multicycle_control_unit: RTL

Multi-cycle control FSM for the 16-bit processor. It replaces the single-cycle combinational decoder with a FETCH/DECODE/EXEC/MEM/WB sequencer that drives datapath enables. It also adds ready-handshakes to instruction and data memory, a wait-timeout, illegal-opcode detection and a HALT instruction. It sits between the instruction register (opcode/function_code fields) and the register file, ALU, PC and memory interfaces.

---
 rtl/multicycle_control_unit.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath enables, with
//            memory ready handshakes, wait timeout, illegal-op and HALT.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int unsigned           OPCODE_W    = 4,
    parameter int unsigned           FUNCT_W     = 4,
    parameter int unsigned           ALUOP_W     = 4,
    parameter int unsigned           TIMEOUT     = 16,
    parameter logic [OPCODE_W-1:0]   HALT_OPCODE = OPCODE_W'(4'hF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  function_code,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_inc,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                Branch,
    output logic                branch_ne,
    output logic                Jump,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic                ALUSource,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegWriteSource,
    output logic                illegal_op,
    output logic                bus_error,
    output logic                halted,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   op_q, op_d;
    logic [FUNCT_W-1:0]    fn_q, fn_d;

    logic                  w_is_r, w_is_lw, w_is_sw, w_is_addi;
    logic                  w_is_beq, w_is_bne, w_is_jmp, w_is_halt;
    logic                  w_r_legal;
    logic [ALUOP_W-1:0]    w_r_aluop;
    logic                  w_waiting;
    logic                  w_timeout;

    assign w_is_r    = (op_q == OPCODE_W'(0));
    assign w_is_lw   = (op_q == OPCODE_W'(1));
    assign w_is_sw   = (op_q == OPCODE_W'(2));
    assign w_is_addi = (op_q == OPCODE_W'(3));
    assign w_is_beq  = (op_q == OPCODE_W'(4));
    assign w_is_bne  = (op_q == OPCODE_W'(5));
    assign w_is_jmp  = (op_q == OPCODE_W'(6));
    assign w_is_halt = (op_q == HALT_OPCODE);
    assign w_r_legal = (fn_q <= FUNCT_W'(3));
    assign w_r_aluop = ALUOP_W'(fn_q);

    // A wait cycle is one spent in a memory phase whose ready is still low.
    assign w_waiting = ((state_q == S_FETCH) && !imem_ready) ||
                       ((state_q == S_MEM)   && !dmem_ready);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int unsigned          CNT_W   = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0]     C_LIMIT = CNT_W'(TIMEOUT - 1);
            localparam logic [CNT_W-1:0]     C_MAX   = CNT_W'(TIMEOUT);

            logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

            // Fires on the TIMEOUT-th consecutive wait cycle; ready wins a tie.
            assign w_timeout = w_waiting && (wait_cnt_q == C_LIMIT);

            always_comb begin
                wait_cnt_d = '0;
                if (w_waiting && !w_timeout) begin
                    wait_cnt_d = (wait_cnt_q == C_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wait_cnt_q <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_d;
                end
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        fn_d           = fn_q;
        imem_req       = 1'b0;
        ir_write       = 1'b0;
        pc_inc         = 1'b0;
        RegDst         = 1'b0;
        RegWrite       = 1'b0;
        Branch         = 1'b0;
        branch_ne      = 1'b0;
        Jump           = 1'b0;
        ALUop          = '0;
        ALUSource      = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        RegWriteSource = 1'b0;
        illegal_op     = 1'b0;
        bus_error      = 1'b0;
        halted         = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_inc   = 1'b1;
                    state_d  = S_DECODE;
                end else if (w_timeout) begin
                    bus_error = 1'b1;
                end
            end
            S_DECODE: begin
                op_d    = opcode;
                fn_d    = function_code;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (w_is_r && w_r_legal) begin
                    ALUop   = w_r_aluop;
                    RegDst  = 1'b1;
                    state_d = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    ALUSource = 1'b1;
                    state_d   = S_MEM;
                end else if (w_is_addi) begin
                    ALUSource = 1'b1;
                    state_d   = S_WB;
                end else if (w_is_beq || w_is_bne) begin
                    Branch    = 1'b1;
                    branch_ne = w_is_bne;
                    ALUop     = ALUOP_W'(1);
                end else if (w_is_jmp) begin
                    Jump = 1'b1;
                end else if (w_is_halt) begin
                    state_d = S_HALT;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            S_MEM: begin
                ALUSource = 1'b1;
                MemRead   = w_is_lw;
                MemWrite  = w_is_sw;
                if (dmem_ready) begin
                    state_d = w_is_lw ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    bus_error = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_WB: begin
                RegWrite       = 1'b1;
                RegDst         = w_is_r;
                RegWriteSource = w_is_lw;
                ALUop          = w_is_r ? w_r_aluop : '0;
                ALUSource      = !w_is_r;
                state_d        = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Hold every control output quiet while reset is asserted.
        if (!rst_n) begin
            imem_req       = 1'b0;
            ir_write       = 1'b0;
            pc_inc         = 1'b0;
            RegDst         = 1'b0;
            RegWrite       = 1'b0;
            Branch         = 1'b0;
            branch_ne      = 1'b0;
            Jump           = 1'b0;
            ALUop          = '0;
            ALUSource      = 1'b0;
            MemRead        = 1'b0;
            MemWrite       = 1'b0;
            RegWriteSource = 1'b0;
            illegal_op     = 1'b0;
            bus_error      = 1'b0;
            halted         = 1'b0;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire
